// File: rtl/wishbone_slave_mem.sv
// Wishbone classic slave backed by a DEPTH x 32-bit register memory.
// Responds after WAIT_STATES extra cycles with a single-cycle ACK.
// Optional macro WB_SLAVE_MEM_ERR_EN adds o_ERR, which replaces o_ACK on an address miss.
module wishbone_slave_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_CYC,
  input  logic                  i_STB,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [3:0]            i_SEL,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_ACK,
  input  logic                  i_TAGN,
  output logic                  o_TAGN
`ifdef WB_SLAVE_MEM_ERR_EN
  ,
  output logic                  o_ERR
`endif
);

  localparam int unsigned NUM_BYTES = 4;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = 4;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   we_q, we_d;
  logic [3:0]             sel_q, sel_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   hit_q, hit_d;
`ifdef WB_SLAVE_MEM_ERR_EN
  logic                   err_q, err_d;
`endif

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   req_c;
  logic [ADDR_WIDTH-1:0]  offset_c;
  logic                   live_hit_c;
  logic [IDX_W-1:0]       live_idx_c;
  logic                   cur_hit_c;
  logic                   cur_we_c;
  logic [IDX_W-1:0]       cur_idx_c;
  logic                   go_ack_c;
  logic                   mem_we_c;
  logic                   unused_c;

  assign unused_c = i_TAGN;
  assign o_TAGN   = 1'b0;
  assign o_ACK    = ack_q;
  assign o_DATA   = rdata_q;
`ifdef WB_SLAVE_MEM_ERR_EN
  assign o_ERR    = err_q;
`endif

  // Address decode of the live bus and selection of the transfer being answered
  always_comb begin
    req_c      = i_CYC & i_STB;
    offset_c   = i_ADDR - BASE;
    live_hit_c = (offset_c < SPAN);
    live_idx_c = offset_c[IDX_W+1:2];
    if (state_q == IDLE) begin
      cur_hit_c = live_hit_c;
      cur_we_c  = i_WE;
      cur_idx_c = live_idx_c;
    end else begin
      cur_hit_c = hit_q;
      cur_we_c  = we_q;
      cur_idx_c = idx_q;
    end
  end

  // Next-state, request capture and registered response
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    rdata_d  = '0;
    we_d     = we_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    go_ack_c = 1'b0;
    mem_we_c = 1'b0;
`ifdef WB_SLAVE_MEM_ERR_EN
    err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_c) begin
          we_d    = i_WE;
          sel_d   = i_SEL;
          wdata_d = i_DATA;
          idx_d   = live_idx_c;
          hit_d   = live_hit_c;
          if (WAIT_STATES == 0) begin
            state_d  = ACK;
            go_ack_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = ACK;
          go_ack_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d  = IDLE;
        cnt_d    = '0;
        mem_we_c = req_c & we_q & hit_q & ~i_RST;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (go_ack_c) begin
`ifdef WB_SLAVE_MEM_ERR_EN
      if (cur_hit_c) begin
        ack_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
`else
      ack_d = 1'b1;
`endif
      if (cur_hit_c && !cur_we_c) begin
        rdata_d = mem_q[cur_idx_c];
      end
    end
  end

  // Control and response registers, synchronous reset
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
`ifdef WB_SLAVE_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
`ifdef WB_SLAVE_MEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Byte-lane memory write at the edge closing a completed write ACK; contents survive reset
  always_ff @(posedge i_CLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (sel_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Bench for wishbone_slave_mem: three instances (WAIT_STATES 1, 0, 3) against a word-array model.
module tb_wishbone_slave_mem;

  localparam int NU = 3;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] SPAN = 32'd1024;
`ifdef WB_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cyc [NU];
  logic        stb [NU];
  logic        we  [NU];
  logic        tagn_i [NU];
  logic        tagn_o [NU];
  logic        ack [NU];
  logic [31:0] addr [NU];
  logic [31:0] wdat [NU];
  logic [31:0] rdat [NU];
  logic [3:0]  sel [NU];
`ifdef WB_SLAVE_MEM_ERR_EN
  logic        err [NU];
`endif

  logic [31:0] mdl [NU][256];
  int n_checks = 0;
  int n_pass = 0;

  wishbone_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .i_CLK(clk), .i_RST(rst), .i_CYC(cyc[0]), .i_STB(stb[0]), .i_WE(we[0]),
    .i_ADDR(addr[0]), .i_SEL(sel[0]), .i_DATA(wdat[0]), .o_DATA(rdat[0]),
    .o_ACK(ack[0]), .i_TAGN(tagn_i[0]), .o_TAGN(tagn_o[0])
`ifdef WB_SLAVE_MEM_ERR_EN
    , .o_ERR(err[0])
`endif
  );

  wishbone_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .i_CLK(clk), .i_RST(rst), .i_CYC(cyc[1]), .i_STB(stb[1]), .i_WE(we[1]),
    .i_ADDR(addr[1]), .i_SEL(sel[1]), .i_DATA(wdat[1]), .o_DATA(rdat[1]),
    .o_ACK(ack[1]), .i_TAGN(tagn_i[1]), .o_TAGN(tagn_o[1])
`ifdef WB_SLAVE_MEM_ERR_EN
    , .o_ERR(err[1])
`endif
  );

  wishbone_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .i_CLK(clk), .i_RST(rst), .i_CYC(cyc[2]), .i_STB(stb[2]), .i_WE(we[2]),
    .i_ADDR(addr[2]), .i_SEL(sel[2]), .i_DATA(wdat[2]), .o_DATA(rdat[2]),
    .o_ACK(ack[2]), .i_TAGN(tagn_i[2]), .o_TAGN(tagn_o[2])
`ifdef WB_SLAVE_MEM_ERR_EN
    , .o_ERR(err[2])
`endif
  );

  function automatic int ws_of(input int u);
    case (u)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Bus released with random junk on the don't-care lines
  task automatic idle_bus(input int u);
    cyc[u]    = 1'b0;
    stb[u]    = 1'b0;
    we[u]     = 1'($urandom);
    addr[u]   = $urandom;
    sel[u]    = 4'($urandom);
    wdat[u]   = $urandom;
    tagn_i[u] = 1'($urandom);
  endtask

  task automatic check_quiet(input int u, input string tag);
    chk($sformatf("%s u%0d ack", tag, u), 32'(ack[u]), 32'h0);
    chk($sformatf("%s u%0d data", tag, u), rdat[u], 32'h0);
    chk($sformatf("%s u%0d tagn", tag, u), 32'(tagn_o[u]), 32'h0);
`ifdef WB_SLAVE_MEM_ERR_EN
    chk($sformatf("%s u%0d err", tag, u), 32'(err[u]), 32'h0);
`endif
  endtask

  // One complete transfer; starts and ends just after a falling edge
  task automatic xfer(input int u, input bit w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    logic [31:0] off;
    logic [7:0]  idx;
    bit          hit;
    logic [31:0] exp_rd;
    logic [31:0] word;
    int          ws;
    ws     = ws_of(u);
    off    = a - BASE;
    hit    = (off < SPAN);
    idx    = off[9:2];
    exp_rd = (hit && !w) ? mdl[u][idx] : 32'h0;

    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; addr[u] = a; sel[u] = s; wdat[u] = d;
    @(posedge clk);
    for (int i = 0; i <= ws; i++) begin
      @(negedge clk);
      if (i < ws) begin
        check_quiet(u, "wait");
      end else begin
        chk($sformatf("resp u%0d a=%h ack", u, a), 32'(ack[u]), 32'(hit || !ERR_EN));
        chk($sformatf("resp u%0d a=%h data", u, a), rdat[u], exp_rd);
`ifdef WB_SLAVE_MEM_ERR_EN
        chk($sformatf("resp u%0d a=%h err", u, a), 32'(err[u]), 32'(!hit));
`endif
      end
    end
    @(posedge clk);
    #1 idle_bus(u);
    if (w && hit) begin
      word = mdl[u][idx];
      for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
      mdl[u][idx] = word;
    end
    @(negedge clk);
    check_quiet(u, "post");
  endtask

  // Write dropped by removing STB after one wait cycle
  task automatic abort_write(input int u, input logic [31:0] a);
    logic [31:0] old;
    old = mdl[u][a[9:2]];
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = 1'b1; addr[u] = a; sel[u] = 4'hF; wdat[u] = ~old;
    @(posedge clk);
    @(negedge clk);
    check_quiet(u, "abort-w1");
    stb[u] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet(u, "abort");
    end
    idle_bus(u);
    xfer(u, 1'b0, a, 4'hF, 32'h0);
  endtask

  // Write dropped by reset during its first wait cycle
  task automatic reset_write(input int u, input logic [31:0] a);
    logic [31:0] old;
    old = mdl[u][a[9:2]];
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = 1'b1; addr[u] = a; sel[u] = 4'hF; wdat[u] = ~old;
    @(posedge clk);
    @(negedge clk);
    check_quiet(u, "rst-w1");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle_bus(u);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet(u, "rst-after");
    end
    xfer(u, 1'b0, a, 4'hF, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      idle_bus(u);
      cyc[u] = 1'b1; stb[u] = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) check_quiet(u, "reset");
    end
    for (int u = 0; u < NU; u++) idle_bus(u);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill every word so all later reads have a known model value
    for (int u = 0; u < NU; u++)
      for (int i = 0; i < 256; i++)
        xfer(u, 1'b1, 32'(i * 4), 4'hF, $urandom);

    // Full write/readback and single-byte merge
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0);
    xfer(0, 1'b1, 32'h10, 4'h1, 32'h000000AA);
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("merge readback u0", rdat[0], 32'h0);
    xfer(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(1, 1'b1, 32'h13, 4'h1, 32'h000000AA);
    xfer(1, 1'b0, 32'h11, 4'hF, 32'h0);

    // Zero-wait read, empty SEL write, miss and alias checks
    xfer(1, 1'b0, 32'h04, 4'hF, 32'h0);
    xfer(1, 1'b1, 32'h04, 4'h0, 32'h12345678);
    xfer(1, 1'b0, 32'h04, 4'hF, 32'h0);
    for (int u = 0; u < NU; u++) begin
      xfer(u, 1'b0, 32'h400, 4'hF, 32'h0);
      xfer(u, 1'b1, 32'h400, 4'hF, 32'hCAFEF00D);
      xfer(u, 1'b0, 32'h0, 4'hF, 32'h0);
      xfer(u, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0);
      xfer(u, 1'b0, 32'h3FF, 4'hF, 32'h0);
    end

    // Aborts and reset in mid-transfer
    abort_write(2, 32'h20);
    abort_write(0, 32'h24);
    reset_write(2, 32'h08);
    reset_write(0, 32'h08);

    // Randomized traffic
    for (int u = 0; u < NU; u++) begin
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 9) == 0) begin
          a = $urandom;
          if (a < SPAN) a = a + SPAN;
        end else begin
          a = 32'($urandom_range(0, 1023));
        end
        xfer(u, 1'($urandom), a, 4'($urandom), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
